// File: rtl/fetch_pipeline.sv
// Instruction fetch plus three pipeline-register stages feeding the branch predictor.
// Redirects on mispredicts, flushes wrong-path slots to bubbles and drains/halts on HLT.
module fetch_pipeline #(
    parameter logic [11:0] START_ADDR   = 12'h000,
    parameter logic [15:0] BUBBLE_INSTR = 16'hC0E0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic        enable,
    output logic [11:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic [11:0] predict_dst,
    input  logic [11:0] branch_dst,
    input  logic        is_predict_miss,
    input  logic        miss_stage2,
    output logic [15:0] instr0,
    output logic [15:0] instr1,
    output logic [15:0] instr2,
    output logic [15:0] branch_src0,
    output logic [15:0] branch_src1,
    output logic [15:0] branch_src2,
    output logic        valid0,
    output logic        valid1,
    output logic        valid2,
    output logic        halted
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    // Stage 0 starts one below START_ADDR so a not-taken prediction fetches START_ADDR first.
    localparam logic [11:0] RESET_ADDR0 = START_ADDR - 12'd1;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [11:0] addr2;
    logic [11:0] fetch_addr;
    logic        advance;
    logic        fetch_is_hlt;
    logic        stage1_is_hlt;

    assign fetch_addr    = is_predict_miss ? branch_dst : predict_dst;
    assign imem_addr     = fetch_addr;
    assign advance       = enable && ((state == ST_RUN) || (state == ST_DRAIN));
    assign fetch_is_hlt  = (imem_rdata[15:14] == 2'b11) && (imem_rdata[7:4] == 4'b1111);
    assign stage1_is_hlt = valid1 && (instr1[15:14] == 2'b11) && (instr1[7:4] == 4'b1111);

    assign branch_src0 = {4'h0, addr0};
    assign branch_src1 = {4'h0, addr1};
    assign branch_src2 = {4'h0, addr2};
    assign halted      = (state == ST_HALTED);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (exec && enable) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (advance && fetch_is_hlt) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A miss here means the HLT was fetched down the wrong path.
                if (advance) begin
                    if (is_predict_miss)
                        state_next = fetch_is_hlt ? ST_DRAIN : ST_RUN;
                    else if (stage1_is_hlt)
                        state_next = ST_HALTED;
                end
            end
            default: state_next = ST_HALTED;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr0 <= BUBBLE_INSTR;
            instr1 <= BUBBLE_INSTR;
            instr2 <= BUBBLE_INSTR;
            addr0  <= RESET_ADDR0;
            addr1  <= 12'h000;
            addr2  <= 12'h000;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
        end else if (advance) begin
            if (is_predict_miss) begin
                // Flushed slots keep the address of the instruction they displace.
                if (miss_stage2) begin
                    instr2 <= BUBBLE_INSTR;
                    addr2  <= addr1;
                    valid2 <= 1'b0;
                end else begin
                    instr2 <= instr1;
                    addr2  <= addr1;
                    valid2 <= valid1;
                end
                instr1 <= BUBBLE_INSTR;
                addr1  <= addr0;
                valid1 <= 1'b0;
                instr0 <= imem_rdata;
                addr0  <= fetch_addr;
                valid0 <= 1'b1;
            end else begin
                instr2 <= instr1;
                addr2  <= addr1;
                valid2 <= valid1;
                instr1 <= instr0;
                addr1  <= addr0;
                valid1 <= valid0;
                if (state == ST_DRAIN) begin
                    instr0 <= BUBBLE_INSTR;
                    valid0 <= 1'b0;
                end else begin
                    instr0 <= imem_rdata;
                    addr0  <= fetch_addr;
                    valid0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pipeline.sv
// Self-checking bench for fetch_pipeline: directed scenarios plus randomized traffic
// compared against a slot-queue reference model of the fetch/flush/halt rules.
module tb_fetch_pipeline;

    localparam logic [15:0] BUBBLE = 16'hC0E0;
    localparam logic [15:0] HLT    = 16'hC0F0;

    logic        clock = 1'b0;
    logic        reset;
    logic        exec;
    logic        enable;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [11:0] predict_dst;
    logic [11:0] branch_dst;
    logic        is_predict_miss;
    logic        miss_stage2;
    logic [15:0] instr0, instr1, instr2;
    logic [15:0] branch_src0, branch_src1, branch_src2;
    logic        valid0, valid1, valid2;
    logic        halted;

    logic [15:0] rom [0:4095];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        logic [11:0] addr;
        logic        valid;
    } slot_t;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_HALT} mode_t;

    slot_t pipe [3];
    mode_t mode;

    always #5 clock = ~clock;

    assign imem_rdata = rom[imem_addr];

    fetch_pipeline dut (
        .clock          (clock),
        .reset          (reset),
        .exec           (exec),
        .enable         (enable),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .predict_dst    (predict_dst),
        .branch_dst     (branch_dst),
        .is_predict_miss(is_predict_miss),
        .miss_stage2    (miss_stage2),
        .instr0         (instr0),
        .instr1         (instr1),
        .instr2         (instr2),
        .branch_src0    (branch_src0),
        .branch_src1    (branch_src1),
        .branch_src2    (branch_src2),
        .valid0         (valid0),
        .valid1         (valid1),
        .valid2         (valid2),
        .halted         (halted)
    );

    function automatic logic [15:0] safe_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:14] == 2'b11 && w[7:4] == 4'b1111) w[4] = 1'b0;
        return w;
    endfunction

    function automatic slot_t bubble(logic [11:0] a);
        slot_t s;
        s.instr = BUBBLE;
        s.addr  = a;
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic bit is_hlt(slot_t s);
        return s.valid && s.instr[15:14] == 2'b11 && s.instr[7:4] == 4'b1111;
    endfunction

    function automatic void model_reset();
        pipe[0] = bubble(12'hFFF);
        pipe[1] = bubble(12'h000);
        pipe[2] = bubble(12'h000);
        mode    = M_IDLE;
    endfunction

    // One clock of the reference: the pipe is a 3-slot queue, newest slot at index 0.
    function automatic void model_clock(bit ex, bit en, bit miss, bit ms2, logic [11:0] bdst);
        slot_t       old [3];
        logic [11:0] fa;
        if (!en || mode == M_HALT) return;
        if (mode == M_IDLE) begin
            if (ex) mode = M_RUN;
            return;
        end
        old = pipe;
        fa  = miss ? bdst : old[0].addr + 12'd1;
        if (miss) begin
            pipe[2] = ms2 ? bubble(old[1].addr) : old[1];
            pipe[1] = bubble(old[0].addr);
            pipe[0] = '{rom[fa], fa, 1'b1};
            mode    = is_hlt(pipe[0]) ? M_DRAIN : M_RUN;
        end else begin
            pipe[2] = old[1];
            pipe[1] = old[0];
            if (mode == M_RUN) begin
                pipe[0] = '{rom[fa], fa, 1'b1};
                if (is_hlt(pipe[0])) mode = M_DRAIN;
            end else begin
                pipe[0] = bubble(old[0].addr);
                if (is_hlt(pipe[2])) mode = M_HALT;
            end
        end
    endfunction

    task automatic cycle(input bit ex, input bit en, input bit miss, input bit ms2,
                         input logic [11:0] bdst);
        exec            = ex;
        enable          = en;
        is_predict_miss = miss;
        miss_stage2     = ms2;
        branch_dst      = bdst;
        predict_dst     = pipe[0].addr + 12'd1;
        @(posedge clock);
        model_clock(ex, en, miss, ms2, bdst);
        #1;
        exec            = 1'b0;
        is_predict_miss = 1'b0;
        miss_stage2     = 1'b0;
        predict_dst     = pipe[0].addr + 12'd1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset           = 1'b1;
        exec            = 1'b0;
        enable          = 1'b0;
        is_predict_miss = 1'b0;
        miss_stage2     = 1'b0;
        model_reset();
        predict_dst     = pipe[0].addr + 12'd1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        predict_dst = pipe[0].addr + 12'd1;
        #3;
        checks++; if (branch_src0 !== 16'h0FFF) begin errors++; $display("[TB] FAIL reset_src0: got %h expected %h", branch_src0, 16'h0FFF); end
        checks++; if ({branch_src1, branch_src2} !== 32'h0) begin errors++; $display("[TB] FAIL reset_src12: got %h %h expected 0 0", branch_src1, branch_src2); end
        checks++; if ({valid0, valid1, valid2, halted} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {valid0, valid1, valid2, halted}); end
        checks++; if ({instr0, instr1, instr2} !== {BUBBLE, BUBBLE, BUBBLE}) begin errors++; $display("[TB] FAIL reset_instr: got %h %h %h expected bubbles", instr0, instr1, instr2); end
        checks++; if (imem_addr !== 12'h000) begin errors++; $display("[TB] FAIL reset_imem_addr: got %h expected 000", imem_addr); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        cycle(1, 1, 0, 0, 12'h000);
        checks++; if ({valid0, branch_src0} !== {1'b0, 16'h0FFF}) begin errors++; $display("[TB] FAIL exec_idle: got %b %h expected 0 0fff", valid0, branch_src0); end
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 1, 0, 0, 12'h000);
            checks++; if (branch_src0 !== 16'(k - 1)) begin errors++; $display("[TB] FAIL seq_src0_%0d: got %h expected %h", k, branch_src0, 16'(k - 1)); end
            checks++; if ({valid0, instr0} !== {1'b1, rom[k - 1]}) begin errors++; $display("[TB] FAIL seq_instr0_%0d: got %b %h expected 1 %h", k, valid0, instr0, rom[k - 1]); end
            checks++; if (valid2 !== (k == 3)) begin errors++; $display("[TB] FAIL seq_valid2_%0d: got %b expected %b", k, valid2, (k == 3)); end
        end
    endtask

    task automatic test_stage1_miss();
        slot_t prev1;
        prev1 = pipe[1];
        cycle(0, 1, 1, 0, 12'h040);
        checks++; if ({branch_src0, instr0, valid0} !== {16'h0040, rom[12'h040], 1'b1}) begin errors++; $display("[TB] FAIL s1miss_stage0: got %h %h %b expected 0040 %h 1", branch_src0, instr0, valid0, rom[12'h040]); end
        checks++; if ({valid1, instr1} !== {1'b0, BUBBLE}) begin errors++; $display("[TB] FAIL s1miss_stage1: got %b %h expected 0 %h", valid1, instr1, BUBBLE); end
        checks++; if ({valid2, instr2, branch_src2} !== {prev1.valid, prev1.instr, 4'h0, prev1.addr}) begin errors++; $display("[TB] FAIL s1miss_stage2: got %b %h %h expected %b %h %h", valid2, instr2, branch_src2, prev1.valid, prev1.instr, prev1.addr); end
    endtask

    task automatic test_stage2_miss();
        cycle(0, 1, 0, 0, 12'h000);
        cycle(0, 1, 1, 1, 12'h010);
        checks++; if ({valid1, valid2} !== 2'b00) begin errors++; $display("[TB] FAIL s2miss_valid: got %b%b expected 00", valid1, valid2); end
        checks++; if (branch_src0 !== 16'h0010) begin errors++; $display("[TB] FAIL s2miss_src0: got %h expected 0010", branch_src0); end
        checks++; if ({instr0, instr1, instr2} !== {rom[12'h010], BUBBLE, BUBBLE}) begin errors++; $display("[TB] FAIL s2miss_instr: got %h %h %h expected %h %h %h", instr0, instr1, instr2, rom[12'h010], BUBBLE, BUBBLE); end
    endtask

    task automatic test_wrap();
        cycle(0, 1, 1, 0, 12'hFFE);
        cycle(0, 1, 0, 0, 12'h000);
        checks++; if (branch_src0 !== 16'h0FFF) begin errors++; $display("[TB] FAIL wrap_fff: got %h expected 0fff", branch_src0); end
        cycle(0, 1, 0, 0, 12'h000);
        checks++; if ({branch_src0, instr0} !== {16'h0000, rom[0]}) begin errors++; $display("[TB] FAIL wrap_000: got %h %h expected 0000 %h", branch_src0, instr0, rom[0]); end
    endtask

    task automatic test_halt();
        bit ex, en, miss;
        do_reset();
        rom[5] = HLT;
        cycle(1, 1, 0, 0, 12'h000);
        for (int k = 0; k < 6; k++) cycle(0, 1, 0, 0, 12'h000);
        checks++; if ({instr0, branch_src0} !== {HLT, 16'h0005}) begin errors++; $display("[TB] FAIL halt_fetch: got %h %h expected %h 0005", instr0, branch_src0, HLT); end
        cycle(0, 1, 0, 0, 12'h000);
        checks++; if ({halted, valid0, branch_src0, instr1} !== {1'b0, 1'b0, 16'h0005, HLT}) begin errors++; $display("[TB] FAIL halt_drain1: got %b %b %h %h expected 0 0 0005 %h", halted, valid0, branch_src0, instr1, HLT); end
        cycle(0, 1, 0, 0, 12'h000);
        checks++; if ({halted, instr2, branch_src2, branch_src0} !== {1'b1, HLT, 16'h0005, 16'h0005}) begin errors++; $display("[TB] FAIL halt_reach: got %b %h %h %h expected 1 %h 0005 0005", halted, instr2, branch_src2, branch_src0, HLT); end
        for (int k = 0; k < 20; k++) begin
            ex   = 1'($urandom);
            en   = 1'($urandom);
            miss = 1'($urandom);
            cycle(ex, en, miss, 1'($urandom), 12'($urandom));
            checks++; if ({halted, valid0, valid1, valid2, instr2, branch_src0} !== {1'b1, 1'b0, 1'b0, 1'b1, HLT, 16'h0005}) begin errors++; $display("[TB] FAIL halt_frozen_%0d: got %b %b%b%b %h %h", k, halted, valid0, valid1, valid2, instr2, branch_src0); end
            checks++; if ({instr0, instr1} !== {pipe[0].instr, pipe[1].instr}) begin errors++; $display("[TB] FAIL halt_frozen_instr_%0d: got %h %h expected %h %h", k, instr0, instr1, pipe[0].instr, pipe[1].instr); end
        end
        rom[5] = safe_word();
    endtask

    task automatic test_hlt_flush();
        do_reset();
        rom[4] = HLT;
        cycle(1, 1, 0, 0, 12'h000);
        for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, 12'h000);
        checks++; if ({instr0, branch_src1} !== {HLT, 16'h0003}) begin errors++; $display("[TB] FAIL flush_setup: got %h %h expected %h 0003", instr0, branch_src1, HLT); end
        cycle(0, 1, 1, 0, 12'h080);
        checks++; if ({valid0, branch_src0, instr0} !== {1'b1, 16'h0080, rom[12'h080]}) begin errors++; $display("[TB] FAIL flush_redirect: got %b %h %h expected 1 0080 %h", valid0, branch_src0, instr0, rom[12'h080]); end
        checks++; if ({valid1, valid2, branch_src2} !== {1'b0, 1'b1, 16'h0003}) begin errors++; $display("[TB] FAIL flush_stages: got %b %b %h expected 0 1 0003", valid1, valid2, branch_src2); end
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 1, 0, 0, 12'h000);
            checks++; if ({halted, valid0, branch_src0} !== {1'b0, 1'b1, 16'(12'h080 + k)}) begin errors++; $display("[TB] FAIL flush_resume_%0d: got %b %b %h expected 0 1 %h", k, halted, valid0, branch_src0, 16'(12'h080 + k)); end
            checks++; if (instr2 === HLT) begin errors++; $display("[TB] FAIL flush_hlt_leak_%0d: got %h expected non-HLT", k, instr2); end
        end
        rom[4] = safe_word();
    endtask

    task automatic test_enable_freeze();
        do_reset();
        cycle(1, 1, 0, 0, 12'h000);
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 12'h000);
        for (int k = 0; k < 5; k++) begin
            cycle(1'($urandom), 0, 1'($urandom), 1'($urandom), 12'($urandom));
            checks++; if ({branch_src0, instr0, instr1, instr2} !== {4'h0, pipe[0].addr, pipe[0].instr, pipe[1].instr, pipe[2].instr}) begin errors++; $display("[TB] FAIL freeze_%0d: got %h %h %h %h expected %h %h %h %h", k, branch_src0, instr0, instr1, instr2, pipe[0].addr, pipe[0].instr, pipe[1].instr, pipe[2].instr); end
            checks++; if ({valid0, valid1, valid2} !== {pipe[0].valid, pipe[1].valid, pipe[2].valid}) begin errors++; $display("[TB] FAIL freeze_valid_%0d: got %b%b%b expected %b%b%b", k, valid0, valid1, valid2, pipe[0].valid, pipe[1].valid, pipe[2].valid); end
        end
        cycle(0, 1, 0, 0, 12'h000);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if ({branch_src0, valid0, instr0} !== {16'h0FFF, 1'b0, BUBBLE}) begin errors++; $display("[TB] FAIL async_reset: got %h %b %h expected 0fff 0 %h", branch_src0, valid0, instr0, BUBBLE); end
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 0, 12'h000);
            checks++; if ({branch_src0, valid0} !== {16'h0FFF, 1'b0}) begin errors++; $display("[TB] FAIL idle_hold_%0d: got %h %b expected 0fff 0", k, branch_src0, valid0); end
        end
    endtask

    task automatic test_random();
        bit en, miss, ms2;
        do_reset();
        cycle(1, 1, 0, 0, 12'h000);
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 9) != 0);
            miss = ($urandom_range(0, 4) == 0);
            ms2  = 1'($urandom);
            cycle(0, en, miss, ms2, 12'($urandom));
            checks++; if ({valid0, valid1, valid2, halted} !== {pipe[0].valid, pipe[1].valid, pipe[2].valid, 1'b0}) begin errors++; $display("[TB] FAIL rnd_flags_%0d: got %b%b%b%b expected %b%b%b0", n, valid0, valid1, valid2, halted, pipe[0].valid, pipe[1].valid, pipe[2].valid); end
            checks++; if ({instr0, instr1, instr2} !== {pipe[0].instr, pipe[1].instr, pipe[2].instr}) begin errors++; $display("[TB] FAIL rnd_instr_%0d: got %h %h %h expected %h %h %h", n, instr0, instr1, instr2, pipe[0].instr, pipe[1].instr, pipe[2].instr); end
            checks++; if (branch_src0 !== {4'h0, pipe[0].addr}) begin errors++; $display("[TB] FAIL rnd_src0_%0d: got %h expected %h", n, branch_src0, pipe[0].addr); end
            if (pipe[1].valid) begin
                checks++; if (branch_src1 !== {4'h0, pipe[1].addr}) begin errors++; $display("[TB] FAIL rnd_src1_%0d: got %h expected %h", n, branch_src1, pipe[1].addr); end
            end
            if (pipe[2].valid) begin
                checks++; if (branch_src2 !== {4'h0, pipe[2].addr}) begin errors++; $display("[TB] FAIL rnd_src2_%0d: got %h expected %h", n, branch_src2, pipe[2].addr); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = safe_word();
        exec            = 1'b0;
        enable          = 1'b0;
        is_predict_miss = 1'b0;
        miss_stage2     = 1'b0;
        branch_dst      = 12'h000;
        predict_dst     = 12'h000;
        reset           = 1'b1;
        test_reset();
        test_sequential();
        test_stage1_miss();
        test_stage2_miss();
        test_wrap();
        test_halt();
        test_hlt_flush();
        test_enable_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
